// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================
// ahb_pkg : shared AHB-Lite types and helpers for slave blocks
// Rev 1.0
// ============================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HS_BYTE  = 3'd0,
    HS_HALF  = 3'd1,
    HS_WORD  = 3'd2,
    HS_DWORD = 3'd3,
    HS_4W    = 3'd4,
    HS_8W    = 3'd5,
    HS_16W   = 3'd6,
    HS_32W   = 3'd7
  } hsize_e;

  typedef enum logic {
    HR_OKAY  = 1'b0,
    HR_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_e;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

  // Lane-address width, kept at least 1 so an 8-bit bus still has a legal vector.
  function automatic int lane_bits(input int data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_mem_slave_param_if.sv
`default_nettype none
// ============================================================
// ahb_mem_slave_param_if : AHB-Lite slave-slot bus bundle
// Rev 1.0
// ============================================================
interface ahb_mem_slave_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface
`default_nettype wire

// File: rtl/ahb_wstrb_gen.sv
`default_nettype none
// ============================================================
// ahb_wstrb_gen : HSIZE/lane address -> byte strobe and legality
// Rev 1.0
// ============================================================
module ahb_wstrb_gen
  import ahb_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int c_nb   = strb_width(DATA_W),
  localparam int c_lb   = $clog2(c_nb),
  localparam int c_lbw  = lane_bits(DATA_W)
) (
  input  logic [2:0]       i_hsize,
  input  logic [c_lbw-1:0] i_lane,
  output logic [c_nb-1:0]  o_strb,
  output logic             o_misalign,
  output logic             o_oversize
);
  localparam logic [2:0] c_lb3 = 3'(c_lb);

  int w_lo;
  int w_n;

  // Little-endian: 2^HSIZE lanes starting at the low address bits.
  always_comb begin
    w_lo       = (c_lb == 0) ? 0 : int'(i_lane);
    w_n        = 1 << i_hsize;
    o_oversize = (i_hsize > c_lb3);
    o_misalign = ((w_lo & (w_n - 1)) != 0);
    o_strb     = '0;
    for (int i = 0; i < c_nb; i++) begin
      o_strb[i] = !o_oversize && (i >= w_lo) && (i < w_lo + w_n);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_mem_slave_param.sv
`default_nettype none
// ============================================================
// ahb_mem_slave_param : AHB-Lite memory slave, per-word valid
// Rev 1.0
// ============================================================
module ahb_mem_slave_param
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  ahb_mem_slave_param_if.slave  bus
);
  localparam int         c_nb  = strb_width(DATA_W);
  localparam int         c_lb  = $clog2(c_nb);
  localparam int         c_lbw = lane_bits(DATA_W);
  localparam int         c_iw  = ADDR_W - c_lb;
  localparam int         c_mw  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_ws  = 4'(WAIT_STATES);

  slv_state_e        r_state, w_state_nxt, w_acc_state;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_wr;
  logic [c_mw-1:0]   r_idx;
  logic [c_nb-1:0]   r_strb;
  logic [DATA_W-1:0] r_hrdata;
  logic [DEPTH-1:0]  r_valid;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [c_iw-1:0]   w_idx_full;
  logic [c_mw-1:0]   w_idx;
  logic [c_lbw-1:0]  w_lane;
  logic [c_nb-1:0]   w_strb;
  logic              w_misalign, w_oversize, w_oor;
  logic              w_accept, w_take, w_fwd, w_legal, w_commit;
  logic [DATA_W-1:0] w_rd_data;

  assign w_idx_full = bus.haddr[ADDR_W-1:c_lb];
  assign w_idx      = w_idx_full[c_mw-1:0];
  assign w_lane     = (c_lb == 0) ? '0 : bus.haddr[c_lbw-1:0];

  generate
    if ((c_iw < 31) && (DEPTH >= (1 << c_iw))) begin : g_idx_full_range
      assign w_oor = 1'b0;
    end else begin : g_idx_part_range
      assign w_oor = (w_idx_full >= c_iw'(DEPTH));
    end
  endgenerate

  ahb_wstrb_gen #(.DATA_W(DATA_W)) u_wstrb (
    .i_hsize    (bus.hsize),
    .i_lane     (w_lane),
    .o_strb     (w_strb),
    .o_misalign (w_misalign),
    .o_oversize (w_oversize)
  );

  assign w_accept = bus.hsel && bus.hready &&
                    ((bus.htrans == HT_NONSEQ) || (bus.htrans == HT_SEQ));
  assign w_take   = w_accept && ((r_state == ST_IDLE) || (r_state == ST_LAST) ||
                                 (r_state == ST_ERR2));
  assign w_commit = (r_state == ST_LAST) && r_wr;
  // A write committing at this edge makes its word readable straight away.
  assign w_fwd    = w_commit && (r_idx == w_idx);
  assign w_legal  = !w_oor && !w_oversize && !w_misalign &&
                    (bus.hwrite || r_valid[w_idx] || w_fwd);

  always_comb begin
    w_rd_data = r_mem[w_idx];
    for (int i = 0; i < c_nb; i++) begin
      if (w_fwd && r_strb[i]) w_rd_data[8*i +: 8] = bus.hwdata[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_state = !w_legal ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_LAST);
    case (r_state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (w_accept) begin
          w_state_nxt = w_acc_state;
          w_cnt_nxt   = c_ws;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = ST_LAST;
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_wr     <= 1'b0;
      r_idx    <= '0;
      r_strb   <= '0;
      r_hrdata <= '0;
      r_valid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_commit) r_valid[r_idx] <= 1'b1;
      if (w_take) begin
        r_wr   <= bus.hwrite;
        r_idx  <= w_idx;
        r_strb <= w_strb;
        if (!bus.hwrite) r_hrdata <= w_legal ? w_rd_data : '0;
      end
    end
  end

  // Storage is not reset; only the valid bits say what may be read.
  always_ff @(posedge hclk) begin
    if (w_commit) begin
      for (int i = 0; i < c_nb; i++) begin
        if (r_strb[i]) r_mem[r_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  assign bus.hreadyout = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
  assign bus.hresp     = (r_state == ST_ERR1) || (r_state == ST_ERR2);
  assign bus.hrdata    = r_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_slave_param.sv
`default_nettype none
// ============================================================
// tb_ahb_mem_slave_param : two slave slots (2 waits / 0 waits)
// Rev 1.0
// ============================================================
module tb_ahb_mem_slave_param;

  logic        clk;
  logic        hreset;
  logic        sel;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  int checks   = 0;
  int failures = 0;

  // Reference model: d=0 is the 2-wait slot, d=1 the zero-wait slot.
  logic [31:0] mm     [2][256];
  bit          vm     [2][256];
  logic [31:0] lastrd [2];

  ahb_mem_slave_param_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  ahb_mem_slave_param_if #(.ADDR_W(32), .DATA_W(32)) b0 ();

  wire        rdy   = sel ? b0.hreadyout : b2.hreadyout;
  wire        resp  = sel ? b0.hresp     : b2.hresp;
  wire [31:0] rdata = sel ? b0.hrdata    : b2.hrdata;

  assign b2.hsel   = hsel & ~sel;
  assign b0.hsel   = hsel & sel;
  assign b2.haddr  = haddr;   assign b0.haddr  = haddr;
  assign b2.htrans = htrans;  assign b0.htrans = htrans;
  assign b2.hwrite = hwrite;  assign b0.hwrite = hwrite;
  assign b2.hsize  = hsize;   assign b0.hsize  = hsize;
  assign b2.hwdata = hwdata;  assign b0.hwdata = hwdata;
  assign b2.hready = rdy;     assign b0.hready = rdy;

  ahb_mem_slave_param #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(2)) dut_w2 (
    .hclk (clk), .hreset (hreset), .bus (b2)
  );
  ahb_mem_slave_param #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) dut_w0 (
    .hclk (clk), .hreset (hreset), .bus (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      lastrd[d] = 32'h0;
      for (int i = 0; i < 256; i++) vm[d][i] = 1'b0;
    end
  endtask

  // One non-pipelined transfer; expectations come from the model before it runs.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input int sz,
                      input logic [31:0] wd, input string tag);
    int          idx, ew, low, lane;
    bit          ok, respl;
    logic [31:0] er;
    idx = int'(a >> 2);
    ok  = (idx < 256) && (sz <= 2) && ((a % (1 << sz)) == 0);
    if (ok && !wr) ok = vm[d][idx];
    ew  = ok ? ((d == 0) ? 2 : 0) : 1;
    er  = wr ? lastrd[d] : (ok ? mm[d][idx] : 32'h0);

    sel = (d != 0); hsel = 1'b1; htrans = 2'd2; hwrite = wr; haddr = a; hsize = 3'(sz);
    tick();
    htrans = 2'd0; hwdata = wd;
    low = 0; respl = 1'b0;
    while (rdy !== 1'b1 && low < 20) begin
      respl |= resp;
      low++;
      tick();
    end
    chk({tag, "_waits"}, 32'(low), 32'(ew));
    chk({tag, "_hresp"}, 32'(resp), 32'(!ok));
    chk({tag, "_hrdata"}, rdata, er);
    if (low > 0) chk({tag, "_wait_hresp"}, 32'(respl), 32'(!ok));
    tick();
    hsel = 1'b0;

    if (ok && wr) begin
      for (int b = 0; b < (1 << sz); b++) begin
        lane = int'(a % 4) + b;
        mm[d][idx][8*lane +: 8] = wd[8*lane +: 8];
      end
      vm[d][idx] = 1'b1;
    end
    if (!wr) lastrd[d] = er;
  endtask

  initial begin
    logic [31:0] ra, rw;
    int          rs, rd;
    bit          rwr;

    hreset = 1'b1; sel = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'd0;
    hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
    model_reset();
    tick(); tick();
    chk("rst_w2_hreadyout", 32'(b2.hreadyout), 32'd1);
    chk("rst_w2_hresp",     32'(b2.hresp),     32'd0);
    chk("rst_w2_hrdata",    b2.hrdata,         32'h0);
    chk("rst_w0_hreadyout", 32'(b0.hreadyout), 32'd1);
    chk("rst_w0_hresp",     32'(b0.hresp),     32'd0);
    chk("rst_w0_hrdata",    b0.hrdata,         32'h0);
    hreset = 1'b0;
    tick();

    xfer(0, 1'b1, 32'h10, 2, 32'hA5A5_1234, "wr_word");
    xfer(0, 1'b0, 32'h10, 2, 32'h0, "rd_word");
    chk("rd_word_const", b2.hrdata, 32'hA5A5_1234);

    xfer(0, 1'b1, 32'h13, 0, 32'h7E00_0000, "wr_byte");
    xfer(0, 1'b1, 32'h10, 1, 32'h0000_BEEF, "wr_half");
    xfer(0, 1'b0, 32'h10, 2, 32'h0, "rd_merge");
    chk("rd_merge_const", b2.hrdata, 32'h7EA5_BEEF);

    xfer(0, 1'b0, 32'h40,  2, 32'h0, "err_unwritten");
    xfer(0, 1'b0, 32'h400, 2, 32'h0, "err_range");
    xfer(0, 1'b0, 32'h02,  2, 32'h0, "err_misalign");

    // BUSY then IDLE while selected: no data phase, no memory change.
    sel = 1'b0; hsel = 1'b1; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2; htrans = 2'd1;
    hwdata = 32'hFFFF_FFFF;
    tick();
    chk("busy_hreadyout", 32'(b2.hreadyout), 32'd1);
    chk("busy_hresp",     32'(b2.hresp),     32'd0);
    htrans = 2'd0;
    tick();
    chk("idle_hreadyout", 32'(b2.hreadyout), 32'd1);
    chk("idle_hresp",     32'(b2.hresp),     32'd0);
    hsel = 1'b0;
    tick();
    xfer(0, 1'b0, 32'h10, 2, 32'h0, "rd_after_busy");

    // Zero-wait slot: write then read of the same word in back-to-back address phases.
    sel = 1'b1; hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
    tick();
    hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
    tick();
    htrans = 2'd0;
    chk("fwd_hreadyout", 32'(b0.hreadyout), 32'd1);
    chk("fwd_hresp",     32'(b0.hresp),     32'd0);
    chk("fwd_hrdata",    b0.hrdata,         32'hDEAD_BEEF);
    tick();
    hsel = 1'b0;
    mm[1][8] = 32'hDEAD_BEEF; vm[1][8] = 1'b1; lastrd[1] = 32'hDEAD_BEEF;
    xfer(1, 1'b0, 32'h20, 2, 32'h0, "rd_after_fwd");

    // Reset in the middle of a waited write: abandoned, never committed.
    sel = 1'b0; hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
    tick();
    htrans = 2'd0; hwdata = 32'h1234_5678;
    chk("rstwait_in_wait", 32'(b2.hreadyout), 32'd0);
    hreset = 1'b1;
    #1;
    chk("rstwait_hreadyout", 32'(b2.hreadyout), 32'd1);
    chk("rstwait_hresp",     32'(b2.hresp),     32'd0);
    hsel = 1'b0;
    tick();
    hreset = 1'b0;
    model_reset();
    tick();
    xfer(0, 1'b0, 32'h30, 2, 32'h0, "rd_after_rst");

    for (int n = 0; n < 300; n++) begin
      rd  = int'($urandom_range(0, 1));
      rwr = 1'($urandom_range(0, 1));
      rs  = int'($urandom_range(0, 3));
      rw  = $urandom();
      if ($urandom_range(0, 15) == 0) ra = 32'h400 + 32'($urandom_range(0, 255));
      else                            ra = 32'($urandom_range(0, 63));
      xfer(rd, rwr, ra, rs, rw, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
